// File: rtl/adc_serial_rx.sv
// Serial ADC front end: drives cs_n/sclk and captures one N-bit sample per frame.
// Frame = SETUP, 2*FRAME sclk half-periods, one DONE cycle, then a 2*HALF_DIV quiet gap.
module adc_serial_rx #(
    parameter int N        = 12,
    parameter int HALF_DIV = 4,
    parameter int FRAME    = 16
) (
    input  logic         Clock,
    input  logic         reset,
    input  logic         start,
    input  logic         sdata,
    output logic         cs_n,
    output logic         sclk,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        QUIET = 3'd4
    } state_t;

    localparam logic [8:0] HALF_LAST   = 9'(HALF_DIV - 1);
    localparam logic [8:0] QUIET_LAST  = 9'(2 * HALF_DIV - 1);
    localparam logic [4:0] FRAME_EDGES = 5'(FRAME);

    state_t       state, state_nxt;
    logic [8:0]   div_cnt;
    logic [4:0]   edge_cnt;
    logic [N-1:0] shreg;
    logic         cs_n_nxt, sclk_nxt;
    logic         div_done, rise, accept, div_clr;

    assign div_done = (div_cnt == HALF_LAST);
    assign accept   = (state == IDLE) && start;
    assign rise     = (state == SHIFT) && div_done && !sclk;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Outputs are computed one state ahead so cs_n/sclk can be plain flops.
    always_comb begin
        state_nxt = state;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    cs_n_nxt  = 1'b0;
                end
            end
            SETUP: begin
                cs_n_nxt = 1'b0;
                if (div_done) begin
                    state_nxt = SHIFT;
                    sclk_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                cs_n_nxt = 1'b0;
                sclk_nxt = sclk;
                if (div_done) begin
                    if (!sclk)
                        sclk_nxt = 1'b1;
                    else if (edge_cnt == FRAME_EDGES) begin
                        state_nxt = DONE;
                        cs_n_nxt  = 1'b1;
                    end else
                        sclk_nxt = 1'b0;
                end
            end
            DONE: begin
                state_nxt = QUIET;
            end
            QUIET: begin
                if (div_cnt == QUIET_LAST)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The divider restarts on every state change and on every sclk toggle.
    assign div_clr = (state_nxt != state) || (state == IDLE) || (state == DONE) ||
                     ((state == SHIFT) && div_done);

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            cs_n       <= 1'b1;
            sclk       <= 1'b1;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            shreg      <= '0;
        end else begin
            cs_n       <= cs_n_nxt;
            sclk       <= sclk_nxt;
            busy       <= (state_nxt != IDLE);
            data_valid <= (state == DONE);
            if (state == DONE)
                data_out <= shreg;
            if (div_clr)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 9'd1;
            if (accept)
                edge_cnt <= '0;
            else if (rise)
                edge_cnt <= edge_cnt + 5'd1;
            if (rise)
                shreg <= {shreg[N-2:0], sdata};
        end
    end

endmodule
